// File: rtl/encode_general_register_stream.sv
// Encodes a register-to-register move/ALU request as a 2-3 byte x86 stream (prefix, opcode, ModRM).
// First byte one cycle after accept; holds bytes under out_ready low. Macro: OPERAND_SIZE_PREFIX_EN.
module encode_general_register_stream #(
  parameter int DEFAULT_32 = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_opcode,
  input  logic [1:0] in_size,
  input  logic [2:0] in_dst,
  input  logic [2:0] in_src,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_byte,
  output logic       out_last,
  output logic       error
);

`ifdef OPERAND_SIZE_PREFIX_EN
  typedef enum logic [1:0] {S_IDLE, S_PREFIX, S_OPCODE, S_MODRM} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_OPCODE, S_MODRM} state_t;
`endif

  state_t     r_state;
  state_t     w_next;
  logic [6:0] r_opcode_hi;
  logic       r_w;
  logic [2:0] r_dst;
  logic [2:0] r_src;
  logic       r_error;

  logic w_accept;
  logic w_fire;
  logic w_need_prefix;
  logic w_illegal;
  logic w_unused;

  // Opcode bit 0 is always replaced by the operand-width bit.
  assign w_unused = in_opcode[0];

  assign w_accept      = in_valid & in_ready;
  assign w_fire        = out_valid & out_ready;
  assign w_need_prefix = ((in_size == 2'b01) && (DEFAULT_32 != 0)) ||
                         ((in_size == 2'b10) && (DEFAULT_32 == 0));

`ifdef OPERAND_SIZE_PREFIX_EN
  assign w_illegal = (in_size == 2'b11);
`else
  assign w_illegal = (in_size == 2'b11) | w_need_prefix;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_error     <= 1'b0;
      r_opcode_hi <= 7'd0;
      r_w         <= 1'b0;
      r_dst       <= 3'd0;
      r_src       <= 3'd0;
    end else begin
      r_state <= w_next;
      r_error <= w_accept & w_illegal;
      if (w_accept && !w_illegal) begin
        r_opcode_hi <= in_opcode[7:1];
        r_w         <= (in_size != 2'b00);
        r_dst       <= in_dst;
        r_src       <= in_src;
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_byte  = 8'h00;
    out_last  = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (w_accept && !w_illegal) begin
`ifdef OPERAND_SIZE_PREFIX_EN
          w_next = w_need_prefix ? S_PREFIX : S_OPCODE;
`else
          w_next = S_OPCODE;
`endif
        end
      end
`ifdef OPERAND_SIZE_PREFIX_EN
      S_PREFIX: begin
        out_valid = 1'b1;
        out_byte  = 8'h66;
        if (w_fire) w_next = S_OPCODE;
      end
`endif
      S_OPCODE: begin
        out_valid = 1'b1;
        out_byte  = {r_opcode_hi, r_w};
        if (w_fire) w_next = S_MODRM;
      end
      S_MODRM: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_byte  = {2'b11, r_src, r_dst};
        // No acceptance this cycle: in_ready stays low until IDLE is reached.
        if (w_fire) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign error = r_error;

endmodule

// File: tb/tb_encode_general_register_stream.sv
// Directed bench for encode_general_register_stream with DEFAULT_32 = 1.
module tb_encode_general_register_stream;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_opcode;
  logic [1:0] in_size;
  logic [2:0] in_dst;
  logic [2:0] in_src;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_byte;
  logic       out_last;
  logic       error;

  int total = 0;
  int bad   = 0;

  encode_general_register_stream #(.DEFAULT_32(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_size(in_size), .in_dst(in_dst), .in_src(in_src),
    .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
    .out_last(out_last), .error(error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [7:0] op, input logic [1:0] sz,
                          input logic [2:0] d, input logic [2:0] s);
    in_opcode = op; in_size = sz; in_dst = d; in_src = s;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
  endtask

  // Reference encoding for DEFAULT_32 = 1; returns byte count, 0 means rejected.
  function automatic int model(input logic [7:0] op, input logic [1:0] sz,
                               input logic [2:0] d, input logic [2:0] s,
                               output logic [23:0] bytes);
    logic w;
    bytes = 24'h0;
    w = (sz == 2'b01) || (sz == 2'b10);
    if (sz == 2'b11) return 0;
    if (sz == 2'b01) begin
`ifdef OPERAND_SIZE_PREFIX_EN
      bytes = {2'b11, s, d, op[7:1], w, 8'h66};
      return 3;
`else
      return 0;
`endif
    end
    bytes[7:0]  = {op[7:1], w};
    bytes[15:8] = {2'b11, s, d};
    return 2;
  endfunction

  // Gathers handshaken bytes until out_last; byte k lands in bytes[8k+:8].
  task automatic collect(input bit rnd, output logic [23:0] bytes, output int n,
                         output bit timeout);
    bit done;
    bytes = 24'h0; n = 0; done = 1'b0; timeout = 1'b1;
    for (int k = 0; k < 60; k++) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #0;
      if (out_valid && out_ready) begin
        if (n < 3) bytes[8*n +: 8] = out_byte;
        n++;
        done = out_last;
      end
      tick();
      if (done) begin
        timeout = 1'b0;
        break;
      end
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_opcode = 8'h00; in_size = 2'b00; in_dst = 3'd0; in_src = 3'd0;
    tick(); tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last got %b want 0", out_last); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL reset_error got %b want 0", error); end
    total++; if (out_byte !== 8'h00) begin bad++; $display("FAIL reset_out_byte got %h want 00", out_byte); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_8bit();
    out_ready = 1'b1;
    send_req(8'h88, 2'b00, 3'b000, 3'b011);
    total++; if (out_valid !== 1'b1 || out_byte !== 8'h88 || out_last !== 1'b0) begin
      bad++; $display("FAIL b8_opcode got v=%b %h l=%b want v=1 88 l=0", out_valid, out_byte, out_last); end
    tick();
    total++; if (out_valid !== 1'b1 || out_byte !== 8'hD8 || out_last !== 1'b1) begin
      bad++; $display("FAIL b8_modrm got v=%b %h l=%b want v=1 d8 l=1", out_valid, out_byte, out_last); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b8_modrm_in_ready got %b want 0", in_ready); end
    tick();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL b8_idle got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
  endtask

  task automatic test_prefix();
    logic [23:0] got; int n; bit to;
    send_req(8'h89, 2'b01, 3'b001, 3'b010);
`ifdef OPERAND_SIZE_PREFIX_EN
    collect(1'b0, got, n, to);
    total++; if (to || n != 3 || got !== 24'hD18966) begin
      bad++; $display("FAIL prefix_stream got n=%0d %h to=%b want n=3 d18966", n, got, to); end
`else
    total++; if (error !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL prefix_reject got err=%b v=%b want err=1 v=0", error, out_valid); end
    collect(1'b0, got, n, to);
    total++; if (n != 0) begin bad++; $display("FAIL prefix_no_bytes got n=%0d want 0", n); end
`endif
    total++; if (error !== 1'b0) begin bad++; $display("FAIL prefix_err_clear got %b want 0", error); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1;
    send_req(8'h88, 2'b10, 3'b111, 3'b000);
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) out_ready = 1'b1;
      total++; if (out_valid !== 1'b1 || out_byte !== 8'h89 || out_last !== 1'b0) begin
        bad++; $display("FAIL hold_c%0d got v=%b %h l=%b want v=1 89 l=0", c, out_valid, out_byte, out_last); end
      tick();
    end
    total++; if (out_byte !== 8'hC7 || out_last !== 1'b1) begin
      bad++; $display("FAIL hold_modrm got %h l=%b want c7 l=1", out_byte, out_last); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL hold_end got v=%b want 0", out_valid); end
  endtask

  task automatic test_illegal();
    send_req(8'h01, 2'b11, 3'd2, 3'd5);
    total++; if (error !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL illegal_pulse got e=%b v=%b r=%b want e=1 v=0 r=1", error, out_valid, in_ready); end
    tick();
    total++; if (error !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL illegal_after got e=%b v=%b r=%b want e=0 v=0 r=1", error, out_valid, in_ready); end
  endtask

  task automatic test_reset_midstream();
    logic [23:0] got; int n; bit to;
    send_req(8'h30, 2'b00, 3'd4, 3'd6);
    tick();
    total++; if (out_last !== 1'b1) begin bad++; $display("FAIL mid_reach_modrm got l=%b want 1", out_last); end
    rst_n = 1'b0;
    tick();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_last !== 1'b0) begin
      bad++; $display("FAIL mid_reset got v=%b r=%b l=%b want v=0 r=1 l=0", out_valid, in_ready, out_last); end
    rst_n = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_no_tail got v=%b want 0", out_valid); end
    send_req(8'h02, 2'b10, 3'd3, 3'd1);
    collect(1'b0, got, n, to);
    total++; if (to || n != 2 || got[15:0] !== 16'hCB03) begin
      bad++; $display("FAIL mid_new_req got n=%0d %h want n=2 cb03", n, got[15:0]); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_opcode = 8'h88; in_size = 2'b00; in_dst = 3'd1; in_src = 3'd2;
    in_valid = 1'b1;
    tick();
    total++; if (out_byte !== 8'h88) begin bad++; $display("FAIL b2b_first got %h want 88", out_byte); end
    in_opcode = 8'h00; in_dst = 3'd5; in_src = 3'd7;
    tick();
    total++; if (out_byte !== 8'hD1 || in_ready !== 1'b0) begin
      bad++; $display("FAIL b2b_modrm got %h r=%b want d1 r=0", out_byte, in_ready); end
    tick();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL b2b_gap got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || out_byte !== 8'h00) begin
      bad++; $display("FAIL b2b_second got v=%b %h want v=1 00", out_valid, out_byte); end
    tick();
    total++; if (out_byte !== 8'hFD) begin bad++; $display("FAIL b2b_second_modrm got %h want fd", out_byte); end
    tick();
  endtask

  task automatic test_sweep();
    logic [23:0] exp_b, got; int exp_n, n; bit to;
    logic [7:0] op, opb, mrm;
    for (int sz = 0; sz < 4; sz++)
      for (int d = 0; d < 8; d++)
        for (int s = 0; s < 8; s++) begin
          op = {3'(d), 3'(s), 1'(d), 1'(s)};
          exp_n = model(op, 2'(sz), 3'(d), 3'(s), exp_b);
          send_req(op, 2'(sz), 3'(d), 3'(s));
          if (exp_n == 0) begin
            total++; if (error !== 1'b1 || out_valid !== 1'b0) begin
              bad++; $display("FAIL sweep_rej sz=%0d d=%0d s=%0d got e=%b v=%b", sz, d, s, error, out_valid); end
            tick();
          end else begin
            collect(1'b1, got, n, to);
            total++; if (to || n != exp_n || got !== exp_b) begin
              bad++; $display("FAIL sweep_bytes sz=%0d d=%0d s=%0d got n=%0d %h want n=%0d %h",
                              sz, d, s, n, got, exp_n, exp_b); end
            opb = got[8*(n-2) +: 8];
            mrm = got[8*(n-1) +: 8];
            total++; if (opb[0] !== (sz != 0) || mrm[5:3] !== 3'(s) || mrm[2:0] !== 3'(d)) begin
              bad++; $display("FAIL sweep_decode sz=%0d d=%0d s=%0d got w=%b reg=%0d rm=%0d", sz, d, s, opb[0], mrm[5:3], mrm[2:0]); end
            total++; if (out_valid !== 1'b0) begin
              bad++; $display("FAIL sweep_extra sz=%0d d=%0d s=%0d got v=%b want 0", sz, d, s, out_valid); end
          end
        end
  endtask

  initial begin
    test_reset();
    test_8bit();
    test_prefix();
    test_backpressure();
    test_illegal();
    test_reset_midstream();
    test_back_to_back();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/encode_general_register_stream.md
ENCODE_GENERAL_REGISTER_STREAM -- requirements
Module: encode_general_register_stream

Interface
REQ-001 SHALL have parameter DEFAULT_32, default 1, meaning code segment default operand size: 1 = 32-bit, 0 = 16-bit.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  request present.
REQ-005 SHALL have port in_ready  output  1  block can accept a request this cycle.
REQ-006 SHALL have port in_opcode  input  8  base opcode; bit0 ignored and replaced by the w bit.
REQ-007 SHALL have port in_size  input  2  operand size: 00 = 8-bit, 01 = 16-bit, 10 = 32-bit, 11 = illegal.
REQ-008 SHALL have port in_dst  input  3  destination register sequence code, placed in ModRM r/m.
REQ-009 SHALL have port in_src  input  3  source register sequence code, placed in ModRM reg.
REQ-010 SHALL have port out_valid  output  1  out_byte valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts out_byte.
REQ-012 SHALL have port out_byte  output  8  encoded instruction byte.
REQ-013 SHALL have port out_last  output  1  marks the final byte of an instruction.
REQ-014 SHALL have port error  output  1  one-cycle pulse when a request is rejected.

Function
REQ-015 SHALL capture opcode, size, dst and src into internal registers when in_valid and in_ready are both high.
REQ-016 SHALL implement an FSM with states IDLE, PREFIX, OPCODE, MODRM; in_ready = 1 only in IDLE.
REQ-017 SHALL derive w = 0 for size 00, w = 1 for sizes 01 and 10.
REQ-018 SHALL require a 0x66 prefix when (size 01 and DEFAULT_32 = 1) or (size 10 and DEFAULT_32 = 0).
REQ-019 SHALL transition on an accepted request from IDLE to PREFIX if a prefix is required, else to OPCODE.
REQ-020 SHALL drive out_valid = 1 in PREFIX, OPCODE and MODRM, and 0 in IDLE.
REQ-021 SHALL drive out_byte = 0x66 in PREFIX, {opcode[7:1], w} in OPCODE, and {2'b11, src, dst} in MODRM.
REQ-022 SHALL advance PREFIX->OPCODE->MODRM->IDLE only on a cycle where out_valid and out_ready are both high.
REQ-023 SHALL hold state, out_byte and captured fields stable while out_ready is low (no drop, no duplicate).
REQ-024 SHALL assert out_last only in MODRM.
REQ-025 SHALL give the first output byte one cycle after acceptance; an instruction is 2 or 3 bytes with zero bubbles when out_ready stays high.
REQ-026 SHALL NOT accept a new request in the cycle MODRM completes; the next acceptance is possible in the following IDLE cycle.
REQ-027 SHALL treat an accepted request with size 11 as illegal: pulse error for 1 cycle, emit no bytes, and stay in IDLE.
REQ-028 SHALL treat 8-bit codes 0-7 as AL,CL,DL,BL,AH,CH,DH,BH, and 16/32-bit codes 0-7 as (E)AX,(E)CX,(E)DX,(E)BX,(E)SP,(E)BP,(E)SI,(E)DI; codes pass through unmodified.

Reset
REQ-029 SHALL, on rst_n low at a clock edge, go to IDLE with out_valid = 0, out_last = 0, error = 0, out_byte = 0x00, in_ready = 1 on the next cycle.
REQ-030 SHALL abandon any partially emitted instruction on reset mid-stream, with no further bytes of it emitted.

Configuration
REQ-031 SHALL use macro OPERAND_SIZE_PREFIX_EN: when defined, prefix generation follows REQ-018.
REQ-032 SHALL, when OPERAND_SIZE_PREFIX_EN is undefined, omit the PREFIX state and treat any request that would need a prefix as illegal per REQ-027.

Verification
REQ-033 SHALL cover: DEFAULT_32 = 1, opcode 0x88, size 00, dst 000, src 011, out_ready = 1 -> bytes 0x88, 0xD8 (last) on consecutive cycles.
REQ-034 SHALL cover: DEFAULT_32 = 1, opcode 0x89, size 01, dst 001, src 010 -> 0x66, 0x89, 0xD1 (last); without the macro -> error pulse and no bytes.
REQ-035 SHALL cover: DEFAULT_32 = 1, size 10, opcode 0x88, dst 111, src 000 with out_ready low for 3 cycles at OPCODE -> 0x89 held stable for 4 cycles, then 0xC7.
REQ-036 SHALL cover: size 11 accepted -> error high for exactly 1 cycle, out_valid stays 0, in_ready stays 1.
REQ-037 SHALL cover: rst_n low while in MODRM -> next cycle out_valid = 0, in_ready = 1; a new request then encodes correctly.
REQ-038 SHALL cover: sweep of all 4 sizes x 8 dst x 8 src with random out_ready -> byte stream matches a reference model and the decode of w/reg code round-trips.
